// File: rtl/csa_pkg.sv
// csa_pkg -- shared definitions for the carry-save accumulator.
//   csa_state_e : controller state encodings (ACCUM, RESOLVE, HOLD)
//   *_DEF       : default widths for operand, accumulator and operand counter
package csa_pkg;

  localparam int WIDTH_DEF = 6;
  localparam int ACC_W_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } csa_state_e;

endpackage

// File: rtl/csa_row.sv
// csa_row -- one row of 3:2 carry-save compression (purely combinational).
//   a, b, c  : W-bit addends
//   sum      : bitwise a^b^c
//   majority : bitwise maj(a,b,c), i.e. the carries before being shifted left
module csa_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] majority
);

  assign sum      = a ^ b ^ c;
  assign majority = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator -- sums a set of unsigned operands in redundant carry-save
// form, resolves the sum with one carry-propagate add, then holds the result
// until the consumer takes it.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake; in_data operand, in_last ends the set
//   out_valid/out_ready  : result handshake
//   out_sum              : set sum modulo 2^ACC_W
//   out_count            : operands in the set, saturating at 2^CNT_W-1
//   out_ovf              : true sum did not fit in ACC_W bits
//
// state   | meaning
// ACCUM   | accepting operands into {S,C}; in_ready=1
// RESOLVE | one cycle: S+C registered into out_sum, carry-out folded into flag
// HOLD    | result presented with out_valid=1 until out_ready
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  csa_state_e       state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] row_sum;
  logic [ACC_W-1:0] row_maj;
  logic [ACC_W:0]   full_sum;

  assign x = ACC_W'(in_data);

  csa_row #(.W(ACC_W)) u_row (
    .a        (s_q),
    .b        (c_q),
    .c        (x),
    .sum      (row_sum),
    .majority (row_maj)
  );

  // S+C is always the true sum minus a multiple of 2^ACC_W, so any dropped
  // carry (here or in the compressor) means the true sum overflowed.
  assign full_sum = {1'b0, s_q} + {1'b0, c_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d   = row_sum;
          c_d   = row_maj << 1;
          ovf_d = ovf_q | row_maj[ACC_W-1];
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        sum_d   = full_sum[ACC_W-1:0];
        ovf_d   = ovf_q | full_sum[ACC_W];
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator -- directed and randomized sets checked against a plain
// integer-sum reference model.
module tb_csa_accumulator;

  localparam int WIDTH = 6;
  localparam int ACC_W = 8;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
  localparam int MODV = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int total = 0;
  int bad   = 0;
  int ops[$];

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends ops[] as one set, checks latency, result and an optional stall in
  // HOLD, then completes the handshake. rnd adds idle gaps, random out_ready
  // while no result is pending, and garbage beats while the block is busy.
  task automatic run_set(input bit rnd, input int stall);
    int exp_sum;
    int exp_cnt;
    exp_sum = 0;
    exp_cnt = 0;
    foreach (ops[i]) begin
      if (rnd) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid  = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(ops[i]);
      in_last  = (i == ops.size() - 1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("in_ready_accum", in_ready, 1);
      step();
      exp_sum += ops[i];
      if (exp_cnt < CNT_SAT) exp_cnt++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = WIDTH'($urandom_range(0, 63));
    in_last   = 1'($urandom_range(0, 1));
    chk("out_valid_lat1", out_valid, 0);
    chk("in_ready_resolve", in_ready, 0);
    step();
    chk("out_valid_lat2", out_valid, 1);
    chk("in_ready_hold", in_ready, 0);
    chk("out_sum", out_sum, exp_sum % MODV);
    chk("out_count", out_count, exp_cnt);
    chk("out_ovf", out_ovf, (exp_sum >= MODV) ? 1 : 0);
    for (int k = 0; k < stall; k++) begin
      in_data = WIDTH'($urandom_range(0, 63));
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sum", out_sum, exp_sum % MODV);
      chk("stall_count", out_count, exp_cnt);
      chk("stall_ovf", out_ovf, (exp_sum >= MODV) ? 1 : 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);

    ops = '{7, 14, 28};
    run_set(1'b0, 0);
    ops = '{63, 63, 63, 63, 63};
    run_set(1'b0, 0);
    ops = '{63, 63, 63, 63};
    run_set(1'b0, 0);
    ops = '{42};
    run_set(1'b0, 0);
    ops = '{10, 20, 30};
    run_set(1'b0, 5);

    // Reset in the middle of a set discards it.
    in_valid = 1'b1; in_data = 6'd5; in_last = 1'b0;
    step();
    in_data = 6'd6;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midset_rst_in_ready", in_ready, 1);
    chk("midset_rst_count", out_count, 0);
    chk("midset_rst_sum", out_sum, 0);
    ops = '{1, 2};
    run_set(1'b0, 0);

    // Reset while a result is pending discards it.
    in_valid = 1'b1; in_data = 6'd33; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("hold_pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_in_ready", in_ready, 1);
    chk("hold_rst_sum", out_sum, 0);
    chk("hold_rst_ovf", out_ovf, 0);

    ops = {};
    for (int i = 0; i < 17; i++) ops.push_back(1);
    run_set(1'b0, 0);

    for (int s = 0; s < 15; s++) begin
      int n;
      n = $urandom_range(1, 20);
      ops = {};
      for (int i = 0; i < n; i++) ops.push_back($urandom_range(0, 63));
      run_set(1'b1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the unsigned operand width in bits.
REQ-002 The block SHALL have parameter ACC_W, default 8, giving the accumulator and result width in bits; ACC_W >= WIDTH.
REQ-003 The block SHALL have parameter CNT_W, default 4, giving the operand-counter width in bits.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  in_data and in_last are valid this cycle.
REQ-007 in_ready  output  1  the block accepts an operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 in_last  input  1  this operand is the final one of the current set.
REQ-010 out_valid  output  1  out_sum, out_count and out_ovf are valid.
REQ-011 out_ready  input  1  the consumer takes the result this cycle.
REQ-012 out_sum  output  ACC_W  sum of the set, modulo 2^ACC_W.
REQ-013 out_count  output  CNT_W  number of operands in the set, saturating.
REQ-014 out_ovf  output  1  the true sum exceeded 2^ACC_W-1.

Function
REQ-015 The FSM SHALL have three states: ACCUM (in_ready=1, out_valid=0), RESOLVE (in_ready=0, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A beat SHALL be accepted in ACCUM when in_valid=1; an accepted beat zero-extends in_data to ACC_W as x.
REQ-017 On acceptance the block SHALL update the redundant state {S,C} as S' = S^C^x and C' = (maj(S,C,x) << 1) truncated to ACC_W bits.
REQ-018 A 1 in bit ACC_W-1 of maj(S,C,x) that is shifted out SHALL set the sticky overflow flag.
REQ-019 Each acceptance SHALL increment the operand count, saturating at 2^CNT_W-1.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM ACCUM->RESOLVE.
REQ-021 In RESOLVE the block SHALL register out_sum = (S'+C') mod 2^ACC_W, OR the carry-out of that addition into the flag, and move to HOLD.
REQ-022 out_valid SHALL assert exactly 2 cycles after the cycle in which the last beat is accepted.
REQ-023 In HOLD, out_sum, out_count and out_ovf SHALL remain stable until out_valid and out_ready are both 1.
REQ-024 On the HOLD handshake the block SHALL clear S, C, the count and the flag and return to ACCUM; in_ready SHALL re-assert on the following cycle.
REQ-025 in_valid in RESOLVE or HOLD SHALL be ignored, and no state SHALL change.
REQ-026 A first beat with in_last=1 SHALL yield out_sum equal to the zero-extended operand and out_count=1.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 When rst=1 at a clock edge, regardless of state, the FSM SHALL go to ACCUM and S, C, the count, the flag, out_sum and out_count SHALL all be cleared to 0.
REQ-029 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 from the first cycle after the reset edge.
REQ-030 An in-flight set or pending result SHALL be discarded by reset.

Structure
REQ-031 The shared package csa_pkg SHALL hold the state encodings (ACCUM, RESOLVE, HOLD) and the default values of WIDTH, ACC_W and CNT_W.
REQ-032 The 3:2 compression SHALL be a combinational sub-module csa_row, parametrised by width, with outputs sum and majority; csa_accumulator SHALL instantiate one csa_row.

Verification
REQ-033 Operands 7, 14, 28 (in_last on 28), out_ready=1 -> out_sum=49, out_count=3, out_ovf=0, with out_valid 2 cycles after the 28 beat.
REQ-034 Five operands of 63, the last flagged -> out_sum=59, out_count=5, out_ovf=1; four operands of 63 -> out_sum=252, out_ovf=0.
REQ-035 Single operand 42 with in_last=1 -> out_sum=42, out_count=1, out_ovf=0.
REQ-036 out_ready held low for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no beat accepted; out_ready=1 -> handshake, then in_ready=1 the next cycle.
REQ-037 rst pulsed after two accepted beats, then operands 1, 2 (last) -> out_sum=3, out_count=2.
REQ-038 Seventeen operands of 1 with CNT_W=4 -> out_count=15, out_sum=17.
